mouse_cdc_sync: RTL and testbench

Parametrised synchroniser that brings mouse position and button state from the mouse clock domain into the pixel clock domain. Position buses are transferred coherently using a toggle request/acknowledge handshake and clamped to the visible area. Button lines are synchronised per bit, optionally debounced, and produce edge pulses. The block sits between the mouse controller and the drawing pipeline that runs on clk65MHz.

---
 rtl/mouse_cdc_sync.sv | 75 +++++++
 tb/tb_mouse_cdc_sync.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mouse_cdc_sync.sv
// mouse_cdc_sync: moves mouse position (toggle handshake, clamped) and buttons (synchronised, edge pulses) into clk65MHz.
// Define MOUSE_DEBOUNCE_EN to add a per-button stable-count debounce filter.
module mouse_cdc_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int POS_W           = 12,
    parameter int BTN_N           = 3,
    parameter int X_MAX           = 1023,
    parameter int Y_MAX           = 767,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic             clk65MHz,
    input  logic             rst_n,
    input  logic             pos_req_tgl,
    input  logic [POS_W-1:0] xpos_in,
    input  logic [POS_W-1:0] ypos_in,
    input  logic [BTN_N-1:0] btn_in,
    output logic             pos_ack_tgl,
    output logic [POS_W-1:0] xpos_out,
    output logic [POS_W-1:0] ypos_out,
    output logic             pos_valid,
    output logic [BTN_N-1:0] btn_out,
    output logic [BTN_N-1:0] btn_rise,
    output logic [BTN_N-1:0] btn_fall
);
    localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);
    logic [SYNC_STAGES-1:0]            req_sync;
    logic [SYNC_STAGES-1:0][BTN_N-1:0] btn_sync;
    logic                              capture;
    logic [BTN_N-1:0]                  btn_s;
    logic [BTN_N-1:0]                  btn_next;
    assign capture = req_sync[SYNC_STAGES-1] ^ pos_ack_tgl;
    assign btn_s   = btn_sync[SYNC_STAGES-1];
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            req_sync    <= '0;
            btn_sync    <= '0;
            pos_ack_tgl <= 1'b0;
            pos_valid   <= 1'b0;
            xpos_out    <= '0;
            ypos_out    <= '0;
            btn_out     <= '0;
            btn_rise    <= '0;
            btn_fall    <= '0;
        end else begin
            req_sync    <= {req_sync[SYNC_STAGES-2:0], pos_req_tgl};
            btn_sync    <= {btn_sync[SYNC_STAGES-2:0], btn_in};
            pos_valid   <= capture;
            pos_ack_tgl <= req_sync[SYNC_STAGES-1];
            if (capture) begin
                xpos_out <= (xpos_in > X_LIM) ? X_LIM : xpos_in;
                ypos_out <= (ypos_in > Y_LIM) ? Y_LIM : ypos_in;
            end
            btn_out  <= btn_next;
            btn_rise <= btn_next & ~btn_out;
            btn_fall <= ~btn_next & btn_out;
        end
    end
`ifdef MOUSE_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic [BTN_N-1:0] flip;
    assign btn_next = btn_out ^ flip;
    // Count consecutive mismatch cycles; flip once the level has held for DEBOUNCE_CYCLES.
    for (genvar b = 0; b < BTN_N; b++) begin : g_deb
        logic [CW-1:0] cnt;
        assign flip[b] = (btn_s[b] != btn_out[b]) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
        always_ff @(posedge clk65MHz or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else cnt <= (btn_s[b] == btn_out[b] || flip[b]) ? '0 : cnt + 1'b1;
        end
    end
`else
    assign btn_next = btn_s;
`endif
endmodule

// File: tb/tb_mouse_cdc_sync.sv
// tb_mouse_cdc_sync: directed self-checking bench for mouse_cdc_sync (set MOUSE_DEBOUNCE_EN to test the debounce build).
module tb_mouse_cdc_sync;
    localparam int S = 2;
    localparam int D = 8;
    logic        clk65MHz = 1'b0;
    logic        rst_n;
    logic        pos_req_tgl;
    logic [11:0] xpos_in, ypos_in;
    logic [2:0]  btn_in;
    logic        pos_ack_tgl, pos_valid;
    logic [11:0] xpos_out, ypos_out;
    logic [2:0]  btn_out, btn_rise, btn_fall;
    int tests = 0;
    int fails = 0;

    mouse_cdc_sync #(.SYNC_STAGES(S), .POS_W(12), .BTN_N(3), .X_MAX(1023), .Y_MAX(767), .DEBOUNCE_CYCLES(D)) dut (
        .clk65MHz(clk65MHz), .rst_n(rst_n), .pos_req_tgl(pos_req_tgl), .xpos_in(xpos_in), .ypos_in(ypos_in),
        .btn_in(btn_in), .pos_ack_tgl(pos_ack_tgl), .xpos_out(xpos_out), .ypos_out(ypos_out), .pos_valid(pos_valid),
        .btn_out(btn_out), .btn_rise(btn_rise), .btn_fall(btn_fall)
    );

    always #5 clk65MHz = ~clk65MHz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk65MHz);
            #1;
        end
    endtask

    task automatic xfer(input logic [11:0] x, input logic [11:0] y, input logic [11:0] ex, input logic [11:0] ey);
        xpos_in = x;
        ypos_in = y;
        pos_req_tgl = ~pos_req_tgl;
        tick(S);
        chk("xfer_early_valid", pos_valid, 0);
        tick(1);
        chk("xfer_valid", pos_valid, 1);
        chk("xfer_x", xpos_out, ex);
        chk("xfer_y", ypos_out, ey);
        chk("xfer_ack", pos_ack_tgl, pos_req_tgl);
        tick(1);
        chk("xfer_valid_drop", pos_valid, 0);
        chk("xfer_x_hold", xpos_out, ex);
    endtask

    logic [11:0] vec [3][4] = '{
        '{12'd1500, 12'd4095, 12'd1023, 12'd767},
        '{12'd1023, 12'd767,  12'd1023, 12'd767},
        '{12'd1024, 12'd768,  12'd1023, 12'd767}
    };

    initial begin
        rst_n = 1'b0;
        pos_req_tgl = 1'b1;
        xpos_in = 12'($urandom);
        ypos_in = 12'($urandom);
        btn_in = 3'($urandom);
        tick(3);
        chk("rst_valid", pos_valid, 0);
        chk("rst_ack", pos_ack_tgl, 0);
        chk("rst_x", xpos_out, 0);
        chk("rst_y", ypos_out, 0);
        chk("rst_btn", btn_out, 0);
        chk("rst_rise", btn_rise, 0);
        chk("rst_fall", btn_fall, 0);
        pos_req_tgl = 1'b0;
        btn_in = 3'b000;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("rel_no_valid", pos_valid, 0);
        end
        xfer(12'd300, 12'd200, 12'd300, 12'd200);
        for (int i = 0; i < 3; i++) xfer(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
`ifdef MOUSE_DEBOUNCE_EN
        xfer(12'd5, 12'd6, 12'd5, 12'd6);
        btn_in = 3'b001;
        tick(5);
        btn_in = 3'b000;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("deb_glitch_out", btn_out, 0);
        end
        btn_in = 3'b001;
        tick(S + D - 1);
        chk("deb_early_out", btn_out, 0);
        tick(1);
        chk("deb_out", btn_out, 3'b001);
        chk("deb_rise", btn_rise, 3'b001);
        tick(1);
        chk("deb_rise_drop", btn_rise, 0);
        btn_in = 3'b000;
        tick(S + D - 1);
        chk("deb_early_rel", btn_out, 3'b001);
        tick(1);
        chk("deb_fall", btn_fall, 3'b001);
        chk("deb_rel_out", btn_out, 0);
`else
        btn_in = 3'b101;
        xpos_in = 12'd50;
        ypos_in = 12'd60;
        pos_req_tgl = ~pos_req_tgl;
        tick(S);
        chk("sim_early_btn", btn_out, 0);
        chk("sim_early_valid", pos_valid, 0);
        tick(1);
        chk("sim_valid", pos_valid, 1);
        chk("sim_rise", btn_rise, 3'b101);
        chk("sim_btn", btn_out, 3'b101);
        chk("sim_x", xpos_out, 50);
        tick(1);
        chk("sim_rise_drop", btn_rise, 0);
        btn_in = 3'b000;
        tick(S + 1);
        chk("fall_out", btn_out, 0);
        chk("fall_pulse", btn_fall, 3'b101);
        btn_in = 3'b010;
        tick(1);
        btn_in = 3'b000;
        tick(S);
        chk("short_out", btn_out, 3'b010);
        chk("short_rise", btn_rise, 3'b010);
        tick(1);
        chk("short_out_drop", btn_out, 0);
        chk("short_fall", btn_fall, 3'b010);
`endif
        // req is 1 and acknowledged here, so the next toggle goes to 0
        xpos_in = 12'd77;
        pos_req_tgl = ~pos_req_tgl;
        tick(1);
        rst_n = 1'b0;
        tick(3);
        chk("mid_rst_x", xpos_out, 0);
        chk("mid_rst_valid", pos_valid, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("mid_rst_no_valid", pos_valid, 0);
        end
        xfer(12'd10, 12'd20, 12'd10, 12'd20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
